// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one burst memory bus between the I-cache and D-cache.
// One burst is outstanding at a time; each beat is routed back to whichever cache owns the bus.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LEN_W-1:0]  bus_len,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t            state_reg, state_next;
  logic              owner_d_reg, owner_d_next;
  logic              last_d_reg, last_d_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              wr_reg, wr_next;
  logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;

  logic addr_ok_pulse;
  logic beat_pulse;
  logic done_pulse;
  logic grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      owner_d_reg  <= 1'b0;
      last_d_reg   <= 1'b1;
      addr_reg     <= '0;
      len_reg      <= '0;
      wr_reg       <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_d_reg  <= owner_d_next;
      last_d_reg   <= last_d_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      wr_reg       <= wr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // D wins a tie only if I was granted last, so neither side can starve the other.
  assign grant_d = d_req && (!i_req || !last_d_reg);

  always_comb begin
    state_next    = state_reg;
    owner_d_next  = owner_d_reg;
    last_d_next   = last_d_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    wr_next       = wr_reg;
    beat_cnt_next = beat_cnt_reg;
    addr_ok_pulse = 1'b0;
    beat_pulse    = 1'b0;
    done_pulse    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d_next = grant_d;
          last_d_next  = grant_d;
          addr_next    = grant_d ? d_addr : i_addr;
          len_next     = grant_d ? d_len : i_len;
          wr_next      = grant_d && d_wr;
          state_next   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A beat without an accept is a bridge protocol error and is dropped.
        if (bus_addr_ok) begin
          addr_ok_pulse = 1'b1;
          beat_cnt_next = '0;
          state_next    = ST_DATA;
          if (bus_data_ok) begin
            beat_pulse = 1'b1;
            if (len_reg == '0) begin
              done_pulse = 1'b1;
              state_next = ST_IDLE;
            end else begin
              beat_cnt_next = LEN_W'(1);
            end
          end
        end
      end
      ST_DATA: begin
        if (bus_data_ok) begin
          beat_pulse = 1'b1;
          // Compare before incrementing so a full 2^LEN_W burst never wraps the counter.
          if (beat_cnt_reg == len_reg) begin
            done_pulse = 1'b1;
            state_next = ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign i_addr_ok = addr_ok_pulse && !owner_d_reg;
  assign d_addr_ok = addr_ok_pulse && owner_d_reg;
  assign i_data_ok = beat_pulse && !owner_d_reg;
  assign d_data_ok = beat_pulse && owner_d_reg;
  assign i_done    = done_pulse && !owner_d_reg;
  assign d_done    = done_pulse && owner_d_reg;
  assign i_rdata   = i_data_ok ? bus_rdata : '0;
  assign d_rdata   = d_data_ok ? bus_rdata : '0;

  assign bus_req   = (state_reg == ST_ADDR);
  assign bus_wr    = wr_reg;
  assign bus_addr  = addr_reg;
  assign bus_len   = len_reg;
  // Write beats stream straight from the D-cache; it advances d_wdata on each d_data_ok.
  assign bus_wdata = ((state_reg != ST_IDLE) && owner_d_reg) ? d_wdata : '0;
  assign busy      = (state_reg != ST_IDLE);

endmodule
